// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: clears the register file after reset or on request, then
// shares its write port and read port 1 between two valid/ready requesters
// with a one-bit round-robin pointer.
//
// state   | meaning
// --------+-----------------------------------------------
// S_CLEAR | writing zero to address cnt, one per cycle
// S_RUN   | arbitrating requester accesses
module rf_port_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          cu_clk,
  input  logic          btn_reset,
  input  logic          clr_req,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wd,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rd,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wd,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rd,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic [AW-1:0] rf_ra1,
  input  logic [DW-1:0] rf_rd1,
  output logic          busy
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic          ptr, ptr_n;
  logic          grant0, grant1;

  // State register: reset always restarts a full clear from address 0
  always_ff @(posedge cu_clk) begin
    if (!btn_reset) begin
      state <= S_CLEAR;
      cnt   <= '0;
      ptr   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
    end
  end

  // Next-state: advance the clear sweep, or hand the pointer to the loser
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    case (state)
      S_CLEAR: begin
        if (cnt == AW'(NREG - 1)) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (clr_req) begin
          state_n = S_CLEAR;
          cnt_n   = '0;
        end else if (grant0) begin
          ptr_n = 1'b1;
        end else if (grant1) begin
          ptr_n = 1'b0;
        end
      end
      default: state_n = S_CLEAR;
    endcase
  end

  // Outputs: grants and register-file port drive; idle ports follow requester ptr
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    busy   = 1'b0;
    rf_we  = 1'b0;
    rf_wa  = ptr ? req1_addr : req0_addr;
    rf_wd  = ptr ? req1_wd   : req0_wd;
    rf_ra1 = ptr ? req1_addr : req0_addr;
    if (btn_reset) begin
      case (state)
        S_CLEAR: begin
          busy  = 1'b1;
          rf_we = 1'b1;
          rf_wa = cnt;
          rf_wd = '0;
        end
        S_RUN: begin
          if (!clr_req) begin
            if (req0_valid && (!req1_valid || !ptr)) grant0 = 1'b1;
            else if (req1_valid)                     grant1 = 1'b1;
          end
          if (grant0) begin
            rf_we  = req0_we;
            rf_wa  = req0_addr;
            rf_wd  = req0_wd;
            rf_ra1 = req0_addr;
          end else if (grant1) begin
            rf_we  = req1_we;
            rf_wa  = req1_addr;
            rf_wd  = req1_wd;
            rf_ra1 = req1_addr;
          end
        end
        default: busy = 1'b0;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Read responses: capture rf_rd1 on a read grant, pulse valid for one cycle
  always_ff @(posedge cu_clk) begin
    if (!btn_reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rd    <= '0;
      rsp1_rd    <= '0;
    end else begin
      rsp0_valid <= grant0 && !req0_we;
      rsp1_valid <= grant1 && !req1_we;
      if (grant0 && !req0_we) rsp0_rd <= rf_rd1;
      if (grant1 && !req1_we) rsp1_rd <= rf_rd1;
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Testbench for rf_port_arbiter: directed scenarios followed by a randomized
// phase, all checked against a behavioural model of the arbiter.
module tb_rf_port_arbiter;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, rf_we, busy;
  logic [DW-1:0] rsp0_rd, rsp1_rd, rf_wd, rf_rd1;
  logic [AW-1:0] rf_wa, rf_ra1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_port_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .cu_clk(clk), .btn_reset(rst_n), .clr_req(clr),
    .req0_valid(v0), .req0_we(we0), .req0_addr(a0), .req0_wd(d0),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rd(rsp0_rd),
    .req1_valid(v1), .req1_we(we1), .req1_addr(a1), .req1_wd(d1),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rd(rsp1_rd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra1(rf_ra1),
    .rf_rd1(rf_rd1), .busy(busy)
  );

  // Register file environment: synchronous write, combinational read
  logic [DW-1:0] rf_mem [NREG];
  always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;
  assign rf_rd1 = rf_mem[rf_ra1];

  // Behavioural model
  int            m_left = 0;
  int            m_idx = 0;
  int            m_ptr = 0;
  logic [DW-1:0] m_mem [NREG];
  logic          m_rv [2];
  logic [DW-1:0] m_rd [2];
  bit            m_known = 0;
  int            last_g = -1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int            g;
    logic          gwe;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    bit            clearing;
    g = -1; gwe = 0; ga = '0; gd = '0;
    clearing = rst_n && (m_left > 0);
    if (rst_n && !clearing && !clr) begin
      if (v0 && v1)  g = m_ptr;
      else if (v0)   g = 0;
      else if (v1)   g = 1;
    end
    if (g == 0) begin gwe = we0; ga = a0; gd = d0; end
    if (g == 1) begin gwe = we1; ga = a1; gd = d1; end

    @(negedge clk);
    chk("busy", 32'(busy), 32'(clearing));
    chk("rf_we", 32'(rf_we), 32'(clearing || (g >= 0 && gwe)));
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    if (clearing) begin
      chk("clear_wa", 32'(rf_wa), 32'(m_idx));
      chk("clear_wd", rf_wd, 32'd0);
    end
    if (g >= 0 && gwe) begin
      chk("wr_wa", 32'(rf_wa), 32'(ga));
      chk("wr_wd", rf_wd, gd);
    end
    if (g >= 0 && !gwe) chk("rd_ra1", 32'(rf_ra1), 32'(ga));
    if (m_known) begin
      chk("rsp0_valid", 32'(rsp0_valid), 32'(m_rv[0]));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(m_rv[1]));
      chk("rsp0_rd", rsp0_rd, m_rd[0]);
      chk("rsp1_rd", rsp1_rd, m_rd[1]);
    end

    @(posedge clk);
    if (!rst_n) begin
      m_left = NREG; m_idx = 0; m_ptr = 0;
      m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
      m_known = 1;
    end else begin
      m_rv[0] = 0; m_rv[1] = 0;
      if (m_left > 0) begin
        m_mem[m_idx] = '0;
        m_idx++;
        m_left--;
      end else if (clr) begin
        m_left = NREG;
        m_idx  = 0;
      end else if (g >= 0) begin
        if (gwe) m_mem[ga] = gd;
        else begin
          m_rv[g] = 1;
          m_rd[g] = m_mem[ga];
        end
        m_ptr = 1 - g;
      end
    end
    last_g = g;
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input int a, input logic [DW-1:0] d);
    v0 = v; we0 = we; a0 = AW'(a); d0 = d;
  endtask

  task automatic set1(input logic v, input logic we, input int a, input logic [DW-1:0] d);
    v1 = v; we1 = we; a1 = AW'(a); d1 = d;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      rf_mem[i] = $urandom;
      m_mem[i]  = 'x;
    end

    // Clear after reset
    rst_n = 0;
    step(); step();
    rst_n = 1;
    for (int i = 0; i < NREG; i++) step();

    // Write then read on requester 0
    set0(1, 1, 5, 32'h0000_00A5); step();
    set0(1, 0, 5, 32'h0);         step();
    set0(0, 0, 5, 32'h0);         step();

    // Requester 1 write moves ptr back to 0
    set1(1, 1, 9, 32'h1234_5678); step();
    set1(0, 0, 9, 32'h0);         step();

    // Contention: both valid for four cycles
    set0(1, 0, 5, 32'h0);
    set1(1, 0, 9, 32'h0);
    for (int i = 0; i < 4; i++) step();
    set0(0, 0, 0, 32'h0); set1(0, 0, 0, 32'h0); step();

    // Clear on demand while req1 waits with a read of addr 5
    set1(1, 0, 5, 32'h0);
    clr = 1; step();
    clr = 0;
    for (int i = 0; i < NREG; i++) step();
    step();
    set1(0, 0, 5, 32'h0); step();

    // Reset mid-clear at cnt=17
    clr = 1; step();
    clr = 0;
    for (int i = 0; i < 17; i++) step();
    rst_n = 0; step();
    rst_n = 1;
    for (int i = 0; i < NREG; i++) step();
    step();

    // Single requester streaming, then contention shows ptr ended at 0
    set1(1, 1, 3, 32'hDEAD_0001); step();
    set1(1, 1, 4, 32'hDEAD_0002); step();
    set1(1, 0, 3, 32'h0);         step();
    set0(1, 0, 4, 32'h0);
    set1(1, 0, 4, 32'h0);         step();
    set0(0, 0, 0, 32'h0);         step();
    set1(0, 0, 0, 32'h0);         step();

    // Randomized traffic honouring the hold-until-ready rule
    for (int n = 0; n < 500; n++) begin
      if (!v0 || last_g == 0) set0(($urandom % 3) != 0, $urandom % 2, $urandom % NREG, $urandom);
      if (!v1 || last_g == 1) set1(($urandom % 3) != 0, $urandom % 2, $urandom % NREG, $urandom);
      clr   = (($urandom % 40) == 0);
      rst_n = (($urandom % 150) != 0);
      step();
    end
    clr = 0; rst_n = 1;
    set0(0, 0, 0, 32'h0); set1(0, 0, 0, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
